inst_fetch_sequencer: RTL and testbench

//   Owns the program counter and sequences the combinational Instruction_Memory:

---
 rtl/inst_fetch_sequencer.sv | 136 +++++++++++++
 tb/tb_inst_fetch_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_sequencer.sv
// ============================================================================
// Module      : inst_fetch_sequencer
// Description : PC owner and fetch queue between Instruction_Memory and decode.
//               Optional FETCH_PERF_EN adds pop and stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_sequencer #(
   parameter int unsigned          ADDR_W    = 64,
   parameter int unsigned          INST_W    = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
   parameter int unsigned          MEM_BYTES = 16,
   parameter int unsigned          QDEPTH    = 2
) (
   input  logic                clk,
   input  logic                reset,
   output logic [ADDR_W-1:0]   Inst_Address,
   input  logic [INST_W-1:0]   Instruction,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic [INST_W-1:0]   inst_out,
   output logic [ADDR_W-1:0]   inst_pc,
   input  logic                redirect_valid,
   input  logic [ADDR_W-1:0]   redirect_pc,
   output logic                halted,
   output logic                fault
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]         perf_fetched,
   output logic [31:0]         perf_stall
`endif
);

   localparam int unsigned        PTR_W   = $clog2(QDEPTH);
   localparam int unsigned        CNT_W   = PTR_W + 1;
   localparam logic [ADDR_W-1:0]  MEM_END = ADDR_W'(MEM_BYTES);
   localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(QDEPTH);

   localparam logic [0:0] FETCH = 1'b0;
   localparam logic [0:0] HALT  = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [INST_W-1:0] q_inst [QDEPTH];
   logic [ADDR_W-1:0] q_pc   [QDEPTH];

   logic full;
   logic pop;
   logic push;
   logic in_range;

   assign Inst_Address = pc;
   assign full         = (count == FULL_CNT);
   assign inst_valid   = (count != '0);
   assign pop          = inst_valid & inst_ready;
   assign in_range     = (pc < MEM_END);
   assign push         = (state == FETCH) & ~redirect_valid & in_range & (~full | pop);
   assign halted       = (state == HALT);

   // Head is a registered-entry read, forced to zero while the queue is empty
   assign inst_out = inst_valid ? q_inst[rd_ptr] : '0;
   assign inst_pc  = inst_valid ? q_pc[rd_ptr]   : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         q_inst[wr_ptr] <= Instruction;
         q_pc[wr_ptr]   <= pc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc     <= RESET_PC;
         state  <= FETCH;
         fault  <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         // Any same-cycle pop is simply absorbed by the flush
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         if (redirect_pc[1:0] != 2'b00) begin
            state <= HALT;
            fault <= 1'b1;
         end else if (redirect_pc < MEM_END) begin
            pc    <= redirect_pc;
            state <= FETCH;
            fault <= 1'b0;
         end else begin
            pc    <= redirect_pc;
            state <= HALT;
         end
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            pc     <= pc + ADDR_W'(4);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (!push && pop) begin
            count <= count - CNT_W'(1);
         end
         if (state == FETCH && !in_range) begin
            state <= HALT;
         end
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop && perf_fetched != '1) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (inst_valid && !inst_ready && perf_stall != '1) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_sequencer.sv
// ============================================================================
// Module      : tb_inst_fetch_sequencer
// Description : Randomized and directed checks of inst_fetch_sequencer against
//               a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] Inst_Address;
   logic [31:0] Instruction;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_out;
   logic [63:0] inst_pc;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        halted;
   logic        fault;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   inst_fetch_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .Inst_Address   (Inst_Address),
      .Instruction    (Instruction),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_out       (inst_out),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .fault          (fault)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   // Program memory: 16 bytes, anything beyond reads a marker word
   logic [31:0] prog [4];

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a < 64'd16) return prog[a[3:2]];
      return 32'hDEAD_BEEF;
   endfunction

   always_comb Instruction = mem_word(Inst_Address);

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        mq[$];
   logic [63:0] m_pc;
   bit          m_halt;
   bit          m_fault;
   int          m_pops;
   int          m_stalls;

   function automatic void model_reset();
      mq.delete();
      m_pc     = '0;
      m_halt   = 1'b0;
      m_fault  = 1'b0;
      m_pops   = 0;
      m_stalls = 0;
   endfunction

   function automatic void model_step(input bit rdy, input bit rv, input logic [63:0] rpc);
      bit   pop;
      bit   room;
      ent_t e;
      pop  = (mq.size() > 0) && rdy;
      room = (mq.size() < 2) || pop;
      if (mq.size() > 0 && !rdy) m_stalls++;
      if (pop) begin
         void'(mq.pop_front());
         m_pops++;
      end
      if (rv) begin
         mq.delete();
         if (rpc[1:0] != 2'b00) begin
            m_halt  = 1'b1;
            m_fault = 1'b1;
         end else if (rpc < 64'd16) begin
            m_pc    = rpc;
            m_halt  = 1'b0;
            m_fault = 1'b0;
         end else begin
            m_pc   = rpc;
            m_halt = 1'b1;
         end
      end else if (!m_halt) begin
         if (m_pc >= 64'd16) begin
            m_halt = 1'b1;
         end else if (room) begin
            e.pc  = m_pc;
            e.ins = mem_word(m_pc);
            mq.push_back(e);
            m_pc = m_pc + 64'd4;
         end
      end
   endfunction

   task automatic tick(input bit rdy, input bit rv, input logic [63:0] rpc);
      inst_ready     = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      model_step(rdy, rv, rpc);
      #1;
      redirect_valid = 1'b0;
   endtask

   task automatic load_prog();
      for (int i = 0; i < 4; i++) prog[i] = $urandom;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      inst_ready = 1'b0;
      redirect_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      load_prog();
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", inst_valid); else n_pass++;
      n_checks++; if (inst_out !== 32'd0) $display("FAIL reset_inst_out got %h want 0", inst_out); else n_pass++;
      n_checks++; if (inst_pc !== 64'd0) $display("FAIL reset_inst_pc got %h want 0", inst_pc); else n_pass++;
      n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
      n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else n_pass++;
      n_checks++; if (Inst_Address !== 64'd0) $display("FAIL reset_addr got %h want 0", Inst_Address); else n_pass++;
   endtask

   task automatic test_stream();
      int          k = 0;
      logic [31:0] exp_ins;
      load_prog();
      apply_reset();
      for (int c = 0; c < 8; c++) begin
         if (inst_valid) begin
            exp_ins = (k < 4) ? prog[k[1:0]] : 32'hxxxx_xxxx;
            n_checks++; if (inst_pc !== 64'(k * 4)) $display("FAIL stream_pc got %h want %h", inst_pc, 64'(k * 4)); else n_pass++;
            n_checks++; if (inst_out !== exp_ins) $display("FAIL stream_inst got %h want %h", inst_out, exp_ins); else n_pass++;
            k++;
         end
         tick(1'b1, 1'b0, '0);
      end
      n_checks++; if (k !== 4) $display("FAIL stream_count got %0d want 4", k); else n_pass++;
      n_checks++; if (halted !== 1'b1) $display("FAIL stream_halted got %b want 1", halted); else n_pass++;
      n_checks++; if (inst_valid !== 1'b0) $display("FAIL stream_drained got %b want 0", inst_valid); else n_pass++;
   endtask

   task automatic test_backpressure();
      int k = 0;
      load_prog();
      apply_reset();
      repeat (5) tick(1'b0, 1'b0, '0);
      n_checks++; if (Inst_Address !== 64'd8) $display("FAIL bp_frozen_pc got %h want 8", Inst_Address); else n_pass++;
      n_checks++; if (inst_pc !== 64'd0 || inst_valid !== 1'b1) $display("FAIL bp_head got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); else n_pass++;
      for (int c = 0; c < 8; c++) begin
         if (inst_valid) begin
            n_checks++; if (inst_pc !== 64'(k * 4)) $display("FAIL bp_order got %h want %h", inst_pc, 64'(k * 4)); else n_pass++;
            k++;
         end
         tick(1'b1, 1'b0, '0);
      end
      n_checks++; if (k !== 4) $display("FAIL bp_count got %0d want 4", k); else n_pass++;
`ifdef FETCH_PERF_EN
      n_checks++; if (perf_stall !== 32'(m_stalls)) $display("FAIL perf_stall got %0d want %0d", perf_stall, m_stalls); else n_pass++;
      n_checks++; if (perf_fetched !== 32'd4) $display("FAIL perf_fetched got %0d want 4", perf_fetched); else n_pass++;
`endif
   endtask

   task automatic test_redirect();
      load_prog();
      apply_reset();
      tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, '0);
      n_checks++; if (inst_pc !== 64'd0) $display("FAIL redir_head got %h want 0", inst_pc); else n_pass++;
      tick(1'b1, 1'b1, 64'd8);
      n_checks++; if (inst_valid !== 1'b0) $display("FAIL redir_flush got %b want 0", inst_valid); else n_pass++;
      n_checks++; if (Inst_Address !== 64'd8) $display("FAIL redir_addr got %h want 8", Inst_Address); else n_pass++;
      tick(1'b0, 1'b0, '0);
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'd8 || inst_out !== prog[2]) $display("FAIL redir_target got v=%b pc=%h ins=%h want v=1 pc=8 ins=%h", inst_valid, inst_pc, inst_out, prog[2]); else n_pass++;
   endtask

   task automatic test_fault();
      load_prog();
      apply_reset();
      tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b1, 64'd6);
      n_checks++; if (fault !== 1'b1 || halted !== 1'b1) $display("FAIL fault_set got f=%b h=%b want 1 1", fault, halted); else n_pass++;
      n_checks++; if (inst_valid !== 1'b0) $display("FAIL fault_empty got %b want 0", inst_valid); else n_pass++;
      n_checks++; if (Inst_Address !== 64'd4) $display("FAIL fault_pc_held got %h want 4", Inst_Address); else n_pass++;
      tick(1'b0, 1'b1, 64'd20);
      n_checks++; if (fault !== 1'b1 || halted !== 1'b1 || Inst_Address !== 64'd20) $display("FAIL oob_redirect got f=%b h=%b a=%h want 1 1 14", fault, halted, Inst_Address); else n_pass++;
      tick(1'b0, 1'b1, 64'd4);
      n_checks++; if (fault !== 1'b0 || halted !== 1'b0) $display("FAIL fault_clear got f=%b h=%b want 0 0", fault, halted); else n_pass++;
      tick(1'b0, 1'b0, '0);
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'd4) $display("FAIL fault_resume got v=%b pc=%h want 1 4", inst_valid, inst_pc); else n_pass++;
   endtask

   task automatic test_random();
      bit          rdy;
      bit          rv;
      logic [63:0] rpc;
      load_prog();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 11) == 0);
         rpc = 64'($urandom_range(0, 23));
         if ($urandom_range(0, 7) == 0) rpc = {$urandom, $urandom};
         if ($urandom_range(0, 49) == 0) load_prog();
         tick(rdy, rv, rpc);
         n_checks++; if (inst_valid !== (mq.size() > 0)) $display("FAIL rnd_valid cyc %0d got %b want %b", c, inst_valid, mq.size() > 0); else n_pass++;
         if (mq.size() > 0) begin
            n_checks++; if (inst_pc !== mq[0].pc || inst_out !== mq[0].ins) $display("FAIL rnd_head cyc %0d got pc=%h ins=%h want pc=%h ins=%h", c, inst_pc, inst_out, mq[0].pc, mq[0].ins); else n_pass++;
         end
         n_checks++; if (halted !== m_halt || fault !== m_fault) $display("FAIL rnd_state cyc %0d got h=%b f=%b want h=%b f=%b", c, halted, fault, m_halt, m_fault); else n_pass++;
         n_checks++; if (Inst_Address !== m_pc) $display("FAIL rnd_addr cyc %0d got %h want %h", c, Inst_Address, m_pc); else n_pass++;
      end
`ifdef FETCH_PERF_EN
      n_checks++; if (perf_fetched !== 32'(m_pops) || perf_stall !== 32'(m_stalls)) $display("FAIL rnd_perf got %0d/%0d want %0d/%0d", perf_fetched, perf_stall, m_pops, m_stalls); else n_pass++;
`endif
   endtask

   task automatic test_async_reset();
      load_prog();
      apply_reset();
      tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b0, '0);
      n_checks++; if (inst_valid !== 1'b1 || Inst_Address !== 64'd8) $display("FAIL async_pre got v=%b a=%h want 1 8", inst_valid, Inst_Address); else n_pass++;
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (inst_valid !== 1'b0) $display("FAIL async_valid got %b want 0", inst_valid); else n_pass++;
      n_checks++; if (Inst_Address !== 64'd0) $display("FAIL async_addr got %h want 0", Inst_Address); else n_pass++;
      n_checks++; if (halted !== 1'b0 || fault !== 1'b0) $display("FAIL async_flags got h=%b f=%b want 0 0", halted, fault); else n_pass++;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick(1'b1, 1'b0, '0);
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'd0 || inst_out !== prog[0]) $display("FAIL async_restart got v=%b pc=%h want 1 0", inst_valid, inst_pc); else n_pass++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_fault();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
